// File: rtl/stochastic_arith_core.sv
// Stochastic-computing arithmetic unit: LFSR encode, combine, count back to binary.
// Optional signed bipolar output guarded by STOCH_SIGNED_OUT_EN.
module stochastic_arith_core #(
  parameter int          WIDTH    = 4,
  parameter int          LOG2_LEN = 3,
  parameter logic [30:0] SEED_A   = 31'd1,
  parameter logic [30:0] SEED_B   = 31'd2,
  parameter logic [30:0] SEED_S   = 31'h5A5A5A5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [1:0]          mode,
  input  logic [WIDTH-1:0]    op_a,
  input  logic [WIDTH-1:0]    op_b,
  output logic                busy,
  output logic                result_valid,
  output logic [LOG2_LEN:0]   result,
  output logic [LOG2_LEN+1:0] result_signed
);

  localparam int N  = 1 << LOG2_LEN;
  localparam int CW = LOG2_LEN + 1;
  localparam int SW = LOG2_LEN + 2;
  localparam logic [LOG2_LEN-1:0] LAST = LOG2_LEN'(N - 1);
  localparam logic [LOG2_LEN-1:0] ONE  = LOG2_LEN'(1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } state_t;

  state_t              state;
  logic [30:0]         lfsr_a;
  logic [30:0]         lfsr_b;
  logic [30:0]         lfsr_s;
  logic [WIDTH-1:0]    op_a_q;
  logic [WIDTH-1:0]    op_b_q;
  logic [1:0]          mode_q;
  logic [LOG2_LEN-1:0] scnt;
  logic                s1_a;
  logic                s1_b;
  logic                s1_sel;
  logic                v1;
  logic                s2_bit;
  logic                v2;
  logic [CW-1:0]       ones;
  logic [CW-1:0]       ones_nxt;
  logic                comb_bit;
  logic                last_flush;

  function automatic logic [30:0] step(input logic [30:0] l);
    return {l[29:0], l[27] ^ l[30]};
  endfunction

  always_comb begin
    comb_bit = ~(s1_a ^ s1_b);
    unique case (1'b1)
      (mode_q == 2'b01): comb_bit = s1_a & s1_b;
      (mode_q == 2'b10): comb_bit = s1_sel ? s1_b : s1_a;
      default:           comb_bit = ~(s1_a ^ s1_b);
    endcase
  end

  // The final sample reaches stage 3 on the same edge that publishes the result.
  assign ones_nxt   = ones + CW'(v2 & s2_bit);
  assign last_flush = (state == FLUSH) && (scnt == ONE);

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state        <= IDLE;
      lfsr_a       <= SEED_A;
      lfsr_b       <= SEED_B;
      lfsr_s       <= SEED_S;
      op_a_q       <= '0;
      op_b_q       <= '0;
      mode_q       <= '0;
      scnt         <= '0;
      s1_a         <= 1'b0;
      s1_b         <= 1'b0;
      s1_sel       <= 1'b0;
      v1           <= 1'b0;
      s2_bit       <= 1'b0;
      v2           <= 1'b0;
      ones         <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      result       <= '0;
    end else begin
      result_valid <= 1'b0;
      v1           <= (state == RUN);
      s1_a         <= lfsr_a[WIDTH-1:0] < op_a_q;
      s1_b         <= lfsr_b[WIDTH-1:0] < op_b_q;
      s1_sel       <= lfsr_s[0];
      v2           <= v1;
      s2_bit       <= comb_bit;
      ones         <= ones_nxt;
      unique case (state)
        IDLE: begin
          if (start) begin
            op_a_q <= op_a;
            op_b_q <= op_b;
            mode_q <= mode;
            lfsr_a <= SEED_A;
            lfsr_b <= SEED_B;
            lfsr_s <= SEED_S;
            scnt   <= '0;
            ones   <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          lfsr_a <= step(lfsr_a);
          lfsr_b <= step(lfsr_b);
          lfsr_s <= step(lfsr_s);
          scnt   <= scnt + ONE;
          if (scnt == LAST) state <= FLUSH;
        end
        FLUSH: begin
          scnt <= scnt + ONE;
          if (last_flush) begin
            result       <= ones_nxt;
            result_valid <= 1'b1;
            busy         <= 1'b0;
            state        <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef STOCH_SIGNED_OUT_EN
  localparam logic [SW-1:0] N_S = SW'(N);

  always_ff @(posedge clk) begin
    if (rst_n) result_signed <= '0;
    else if (last_flush) result_signed <= {ones_nxt, 1'b0} - N_S;
  end
`else
  assign result_signed = '0;
`endif

endmodule

// File: tb/tb_stochastic_arith_core.sv
// Randomized self-checking bench for stochastic_arith_core.
// Expected counts come from a plain arithmetic stream model.
module tb_stochastic_arith_core;

  localparam int W = 4;
  localparam int L = 3;
  localparam int N = 1 << L;
  localparam int SA0 = 1;
  localparam int SB0 = 2;
  localparam int SS0 = 'h5A5A5A5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         busy;
  logic         result_valid;
  logic [L:0]   result;
  logic [L+1:0] result_signed;

  int total = 0;
  int bad = 0;

  stochastic_arith_core #(.WIDTH(W), .LOG2_LEN(L)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .mode(mode),
    .op_a(op_a),
    .op_b(op_b),
    .busy(busy),
    .result_valid(result_valid),
    .result(result),
    .result_signed(result_signed)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int nxt(input int l);
    return ((l << 1) | (((l >> 27) ^ (l >> 30)) & 1)) & 32'h7fffffff;
  endfunction

  // Count of ones in the N-sample combined stream, straight from the mode rules.
  function automatic int model(input int a, input int b, input int m);
    int la = SA0;
    int lb = SB0;
    int ls = SS0;
    int cnt = 0;
    int mask = (1 << W) - 1;
    for (int k = 0; k < N; k++) begin
      int sa = ((la & mask) < a) ? 1 : 0;
      int sb = ((lb & mask) < b) ? 1 : 0;
      int sl = ls & 1;
      if (m == 1) cnt += sa & sb;
      else if (m == 2) cnt += sl ? sb : sa;
      else cnt += (sa == sb) ? 1 : 0;
      la = nxt(la);
      lb = nxt(lb);
      ls = nxt(ls);
    end
    return cnt;
  endfunction

  function automatic int exp_signed(input int c);
`ifdef STOCH_SIGNED_OUT_EN
    return 2 * c - N;
`else
    return 0 * c;
`endif
  endfunction

  task automatic do_txn(input int a, input int b, input int m, output int res);
    int early = 0;
    int c;
    @(negedge clk);
    start = 1'b1;
    op_a = W'(a);
    op_b = W'(b);
    mode = 2'(m);
    @(negedge clk);
    start = 1'b0;
    check("busy_t1", int'(busy), 1);
    for (c = 1; c <= N + 2; c++) begin
      if (c > 1) @(negedge clk);
      if (result_valid) early++;
    end
    check("busy_last", int'(busy), 1);
    check("rv_early", early, 0);
    @(negedge clk);
    check("rv_at_n3", int'(result_valid), 1);
    check("busy_done", int'(busy), 0);
    c = model(a, b, m);
    check("result", int'(result), c);
    check("signed", int'($signed(result_signed)), exp_signed(c));
    res = int'(result);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    repeat (cycles) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_rv", int'(result_valid), 0);
    check("rst_res", int'(result), 0);
    check("rst_sgn", int'(result_signed), 0);
    rst_n = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    int r;
    int r00;
    int r11;
    int cyc;
    int hit;
    int first;
    int second;
    int rv_cnt;

    do_reset(3);

    do_txn(0, 0, 0, r);
    check("bip_zero", r, N);
    do_txn(0, 15, 1, r);
    check("uni_zero", r, 0);
    do_txn(15, 15, 1, r);
    do_txn(0, 0, 2, r);
    check("add_zero", r, 0);

    do_txn(9, 4, 0, r00);
    do_txn(9, 4, 3, r11);
    check("m11_eq_m00", r11, r00);

    // Second start at t+3 must be ignored.
    @(negedge clk);
    start = 1'b1;
    op_a = 4'd3;
    op_b = 4'd5;
    mode = 2'b01;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    hit = 0;
    while (cyc < 3 * N) begin
      @(negedge clk);
      cyc++;
      if (cyc == 3) begin
        start = 1'b1;
        op_a = 4'd12;
        op_b = 4'd9;
        mode = 2'b00;
      end else begin
        start = 1'b0;
      end
      if (result_valid) begin
        hit = cyc;
        break;
      end
    end
    check("hs_latency", hit, N + 3);
    check("hs_result", int'(result), model(3, 5, 1));

    // Held start: one result every N+4 cycles.
    @(negedge clk);
    start = 1'b1;
    op_a = 4'd7;
    op_b = 4'd11;
    mode = 2'b10;
    first = -1;
    second = -1;
    for (int i = 0; i < 4 * (N + 4); i++) begin
      @(negedge clk);
      if (result_valid) begin
        check("hold_res", int'(result), model(7, 11, 2));
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
    end
    check("hold_seen", (second >= 0) ? 1 : 0, 1);
    check("hold_period", second - first, N + 4);
    do_reset(2);

    // Abort with reset at t+5.
    @(negedge clk);
    start = 1'b1;
    op_a = 4'd6;
    op_b = 4'd10;
    mode = 2'b00;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_rv0", int'(result_valid), 0);
    rv_cnt = 0;
    for (int i = 0; i < 2 * N; i++) begin
      @(negedge clk);
      if (result_valid) rv_cnt++;
    end
    check("abort_no_rv", rv_cnt, 0);
    do_txn(6, 10, 0, r);

    for (int i = 0; i < 20; i++) begin
      int a = int'($urandom_range(0, 15));
      int b = int'($urandom_range(0, 15));
      int m = int'($urandom_range(0, 3));
      do_txn(a, b, m, r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
